// File: rtl/mips_trace_harness.sv
// Self-checking stimulus/checker harness for a single-cycle MIPS core: feeds instructions, compares
// ALUresult per executed cycle. Optional data memory is enabled with `define TRACE_DMEM_EN.
module mips_trace_harness #(
    parameter int WIDTH      = 32,
    parameter int IDEPTH     = 64,
    parameter int DDEPTH     = 64,
    parameter int MAX_CYCLES = 256
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    load_en,
    input  logic                    load_sel,
    input  logic [$clog2(IDEPTH)-1:0] load_addr,
    input  logic [WIDTH-1:0]        load_data,
    input  logic [$clog2(IDEPTH):0] prog_len,
    output logic                    cpu_reset,
    input  logic [WIDTH-1:0]        pc,
    output logic [WIDTH-1:0]        instr,
    input  logic                    memwrite,
    input  logic [WIDTH-1:0]        ALUresult,
    input  logic [WIDTH-1:0]        writedata,
    output logic [WIDTH-1:0]        readdata,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic                    timeout,
    output logic [15:0]             err_count,
    output logic [15:0]             cycle_count,
    output logic [WIDTH-1:0]        fail_pc
);

    localparam int AW = $clog2(IDEPTH);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    state_t            state;
    logic              first;
    logic [WIDTH-1:0]  imem    [IDEPTH];
    logic [WIDTH-1:0]  exp_mem [IDEPTH];
    logic [IDEPTH-1:0] exp_valid;

    logic [WIDTH-1:0] pc_word;
    logic [AW-1:0]    pc_idx;
    logic             executing;
    logic             beyond_prog;
    logic             beyond_mem;
    logic             bad_cycle;
    logic [15:0]      err_inc;
    logic [15:0]      cyc_inc;
    logic             load_ok;

    always_comb begin
        pc_word     = {2'b00, pc[WIDTH-1:2]};
        pc_idx      = pc[AW+1:2];
        executing   = (state == StRun) && !first;
        cpu_reset   = !executing;
        busy        = (state == StRun);
        pass        = done && (err_count == 16'd0) && !timeout;
        instr       = executing ? imem[pc_idx] : '0;
        beyond_prog = pc_word >= WIDTH'(prog_len);
        beyond_mem  = pc_word >= WIDTH'(IDEPTH);
        // A misaligned PC is one error on its own; its table entry is not compared.
        bad_cycle   = (pc[1:0] != 2'b00) ||
                      (exp_valid[pc_idx] && (exp_mem[pc_idx] != ALUresult));
        err_inc     = (err_count == 16'hFFFF) ? err_count : err_count + 16'd1;
        cyc_inc     = (cycle_count == 16'hFFFF) ? cycle_count : cycle_count + 16'd1;
        load_ok     = load_en && (state != StRun);
    end

    always_ff @(posedge clk) begin
        if (load_ok) begin
            if (load_sel) exp_mem[load_addr] <= load_data;
            else          imem[load_addr]    <= load_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_valid <= '0;
        end else if (load_ok && load_sel) begin
            exp_valid[load_addr] <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= StIdle;
            first       <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            err_count   <= '0;
            cycle_count <= '0;
            fail_pc     <= '0;
        end else if (start) begin
            state       <= StRun;
            first       <= 1'b1;
            done        <= 1'b0;
            timeout     <= 1'b0;
            err_count   <= '0;
            cycle_count <= '0;
            fail_pc     <= '0;
        end else begin
            case (state)
                StRun: begin
                    if (first) begin
                        first <= 1'b0;
                    end else if (beyond_prog) begin
                        state <= StDone;
                        done  <= 1'b1;
                    end else if (cycle_count == 16'(MAX_CYCLES - 1)) begin
                        state   <= StDone;
                        done    <= 1'b1;
                        timeout <= 1'b1;
                    end else if (beyond_mem) begin
                        state     <= StDone;
                        done      <= 1'b1;
                        err_count <= err_inc;
                        if (err_count == 16'd0) fail_pc <= pc;
                    end else begin
                        cycle_count <= cyc_inc;
                        if (bad_cycle) begin
                            err_count <= err_inc;
                            if (err_count == 16'd0) fail_pc <= pc;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef TRACE_DMEM_EN
    localparam int DW = $clog2(DDEPTH);

    logic [WIDTH-1:0] dmem [DDEPTH];
    logic             d_inrange;
    logic [DW-1:0]    d_idx;
    logic             unused_dmem;

    always_comb begin
        d_inrange   = {2'b00, ALUresult[WIDTH-1:2]} < WIDTH'(DDEPTH);
        d_idx       = ALUresult[DW+1:2];
        readdata    = d_inrange ? dmem[d_idx] : '0;
        unused_dmem = ^ALUresult[1:0];
    end

    always_ff @(posedge clk) begin
        if (memwrite && (state == StRun) && d_inrange) dmem[d_idx] <= writedata;
    end
`else
    logic unused_dmem;

    always_comb begin
        readdata    = '0;
        unused_dmem = ^{memwrite, writedata};
    end
`endif

endmodule

// File: tb/tb_mips_trace_harness.sv
// Self-checking bench for mips_trace_harness: the bench plays the processor, feeding a PC/ALU
// trace, and compares status against a trace-level reference model.
module tb_mips_trace_harness;

    localparam int WIDTH      = 32;
    localparam int IDEPTH     = 64;
    localparam int DDEPTH     = 64;
    localparam int MAX_CYCLES = 256;
    localparam int AW         = 6;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              load_en = 1'b0;
    logic              load_sel = 1'b0;
    logic [AW-1:0]     load_addr = '0;
    logic [WIDTH-1:0]  load_data = '0;
    logic [AW:0]       prog_len = '0;
    logic              cpu_reset;
    logic [WIDTH-1:0]  pc = '0;
    logic [WIDTH-1:0]  instr;
    logic              memwrite = 1'b0;
    logic [WIDTH-1:0]  ALUresult = '0;
    logic [WIDTH-1:0]  writedata = '0;
    logic [WIDTH-1:0]  readdata;
    logic              busy, done, pass, timeout;
    logic [15:0]       err_count, cycle_count;
    logic [WIDTH-1:0]  fail_pc;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_imem [IDEPTH];
    logic [31:0] m_exp  [IDEPTH];
    bit          m_val  [IDEPTH];
    logic [31:0] pcq [$];
    logic [31:0] aluq [$];

    mips_trace_harness #(
        .WIDTH(WIDTH), .IDEPTH(IDEPTH), .DDEPTH(DDEPTH), .MAX_CYCLES(MAX_CYCLES)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .load_en(load_en), .load_sel(load_sel),
        .load_addr(load_addr), .load_data(load_data), .prog_len(prog_len),
        .cpu_reset(cpu_reset), .pc(pc), .instr(instr), .memwrite(memwrite),
        .ALUresult(ALUresult), .writedata(writedata), .readdata(readdata), .busy(busy),
        .done(done), .pass(pass), .timeout(timeout), .err_count(err_count),
        .cycle_count(cycle_count), .fail_pc(fail_pc)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic load_word(input logic sel, input int addr, input logic [31:0] data);
        bit was_busy;
        @(negedge clk);
        was_busy  = busy;
        load_en   = 1'b1;
        load_sel  = sel;
        load_addr = addr[AW-1:0];
        load_data = data;
        @(negedge clk);
        load_en = 1'b0;
        if (!was_busy) begin
            if (sel) begin
                m_exp[addr] = data;
                m_val[addr] = 1'b1;
            end else begin
                m_imem[addr] = data;
            end
        end
    endtask

    // Walk the trace applying the harness rules to predict the final status.
    task automatic model_run(input int plen, output int e_err, output int e_cyc,
                             output logic [31:0] e_fp, output bit e_to);
        e_err = 0; e_cyc = 0; e_fp = 0; e_to = 0;
        foreach (pcq[k]) begin
            int unsigned word;
            int idx;
            word = pcq[k] >> 2;
            idx  = int'(word % IDEPTH);
            if (word >= plen) break;
            if (e_cyc == MAX_CYCLES - 1) begin e_to = 1; break; end
            if (word >= IDEPTH) begin
                if (e_err == 0) e_fp = pcq[k];
                e_err++;
                break;
            end
            e_cyc++;
            if ((pcq[k] % 4 != 0) || (m_val[idx] && m_exp[idx] !== aluq[k])) begin
                if (e_err == 0) e_fp = pcq[k];
                e_err++;
            end
        end
    endtask

    task automatic run_prog(input string name, input int e_err, input int e_cyc,
                            input logic [31:0] e_fp, input bit e_to);
        bit fin;
        fin = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        total++;
        if (busy !== 1 || cpu_reset !== 1 || done !== 0 || err_count !== 0 ||
            cycle_count !== 0 || timeout !== 0) begin
            bad++;
            $display("FAIL %s_start: busy=%b cpu_reset=%b done=%b err=%0d cyc=%0d to=%b, want 1 1 0 0 0 0",
                     name, busy, cpu_reset, done, err_count, cycle_count, timeout);
        end
        for (int k = 0; k < pcq.size() && !fin; k++) begin
            @(negedge clk);
            if (done) begin
                fin = 1;
            end else begin
                int idx;
                pc = pcq[k];
                ALUresult = aluq[k];
                idx = int'((pcq[k] >> 2) % IDEPTH);
                #1;
                total++;
                if (instr !== m_imem[idx] || cpu_reset !== 0) begin
                    bad++;
                    $display("FAIL %s_instr[%0d]: got instr=%h cpu_reset=%b want %h 0",
                             name, k, instr, cpu_reset, m_imem[idx]);
                end
            end
        end
        for (int w = 0; w < 8 && !done; w++) @(negedge clk);
        total++;
        if (done !== 1) begin
            bad++; $display("FAIL %s_done: got %b want 1", name, done);
        end
        total++;
        if (err_count !== 16'(e_err)) begin
            bad++; $display("FAIL %s_err: got %0d want %0d", name, err_count, e_err);
        end
        total++;
        if (cycle_count !== 16'(e_cyc)) begin
            bad++; $display("FAIL %s_cyc: got %0d want %0d", name, cycle_count, e_cyc);
        end
        total++;
        if (fail_pc !== e_fp) begin
            bad++; $display("FAIL %s_fail_pc: got %h want %h", name, fail_pc, e_fp);
        end
        total++;
        if (timeout !== e_to || pass !== (e_err == 0 && !e_to)) begin
            bad++;
            $display("FAIL %s_status: got timeout=%b pass=%b want %b %b",
                     name, timeout, pass, e_to, (e_err == 0 && !e_to));
        end
        total++;
        if (busy !== 0 || cpu_reset !== 1 || instr !== 0) begin
            bad++;
            $display("FAIL %s_idle: got busy=%b cpu_reset=%b instr=%h want 0 1 0",
                     name, busy, cpu_reset, instr);
        end
`ifndef TRACE_DMEM_EN
        total++;
        if (readdata !== 0) begin
            bad++; $display("FAIL %s_readdata: got %h want 0", name, readdata);
        end
`endif
    endtask

    task automatic test_reset();
        #1;
        total++;
        if (cpu_reset !== 1 || busy !== 0 || done !== 0 || pass !== 0 || timeout !== 0 ||
            err_count !== 0 || cycle_count !== 0 || fail_pc !== 0 || instr !== 0 ||
            readdata !== 0) begin
            bad++;
            $display("FAIL reset: cpu_reset=%b busy=%b done=%b pass=%b to=%b err=%0d cyc=%0d fpc=%h instr=%h rd=%h",
                     cpu_reset, busy, done, pass, timeout, err_count, cycle_count, fail_pc,
                     instr, readdata);
        end
        @(negedge clk); reset = 1'b0;
        for (int i = 0; i < IDEPTH; i++) m_val[i] = 1'b0;
    endtask

    task automatic test_match();
        logic [31:0] expv [4];
        expv = '{32'd5, 32'd7, 32'd12, 32'd0};
        for (int i = 0; i < 4; i++) load_word(1'b0, i, $urandom);
        for (int i = 0; i < 4; i++) load_word(1'b1, i, expv[i]);
        prog_len = 7'd4;
        pcq = '{0, 4, 8, 12, 16};
        aluq = '{5, 7, 12, 0, 0};
        run_prog("match", 0, 4, 32'h0, 0);
    endtask

    task automatic test_mismatch();
        load_word(1'b1, 2, 32'd13);
        run_prog("mismatch", 1, 4, 32'h8, 0);
    endtask

    task automatic test_rerun();
        run_prog("rerun", 1, 4, 32'h8, 0);
    endtask

    task automatic test_misaligned();
        prog_len = 7'd3;
        pcq = '{0, 6, 8, 12};
        aluq = '{m_exp[0], 0, m_exp[2], 0};
        run_prog("misaligned", 1, 3, 32'h6, 0);
    endtask

    task automatic test_boundary();
        load_word(1'b0, 63, $urandom);
        load_word(1'b1, 63, $urandom);
        prog_len = 7'd100;
        pcq = '{0, 252, 256};
        aluq = '{m_exp[0], m_exp[63], 0};
        run_prog("beyond_imem", 1, 2, 32'd256, 0);
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            int plen, e_err, e_cyc;
            logic [31:0] e_fp;
            bit e_to;
            plen = $urandom_range(1, 24);
            for (int i = 0; i < plen; i++) begin
                load_word(1'b0, i, $urandom);
                if ($urandom % 4 != 0) load_word(1'b1, i, $urandom);
            end
            prog_len = 7'(plen);
            pcq.delete();
            aluq.delete();
            for (int i = 0; i < plen; i++) begin
                pcq.push_back(32'(4 * i) + (($urandom % 10 == 0) ? 32'd2 : 32'd0));
                aluq.push_back(($urandom % 10 < 7) ? m_exp[i] : $urandom);
            end
            pcq.push_back(32'(4 * plen));
            aluq.push_back(32'd0);
            model_run(plen, e_err, e_cyc, e_fp, e_to);
            run_prog($sformatf("random%0d", it), e_err, e_cyc, e_fp, e_to);
        end
    endtask

    task automatic test_load_busy();
        logic [31:0] old;
        old = m_imem[0];
        prog_len = 7'd1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        pc = 0; ALUresult = m_exp[0];
        load_en = 1'b1; load_sel = 1'b0; load_addr = '0; load_data = ~old;
        @(negedge clk);
        load_en = 1'b0;
        #1;
        total++;
        if (instr !== old) begin
            bad++; $display("FAIL load_busy: got instr=%h want %h", instr, old);
        end
        @(negedge clk); pc = 32'd4;
        for (int w = 0; w < 8 && !done; w++) @(negedge clk);
        total++;
        if (done !== 1) begin
            bad++; $display("FAIL load_busy_done: got %b want 1", done);
        end
    endtask

    task automatic test_timeout();
        prog_len = 7'd4;
        pcq.delete();
        aluq.delete();
        for (int i = 0; i < 300; i++) begin
            pcq.push_back(32'd0);
            aluq.push_back(m_exp[0]);
        end
        run_prog("timeout", 0, MAX_CYCLES - 1, 32'h0, 1);
    endtask

    task automatic test_reset_midrun();
        prog_len = 7'd20;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); pc = 32'(4 * i); ALUresult = ~m_exp[i];
        end
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        total++;
        if (busy !== 0 || cpu_reset !== 1 || instr !== 0 || cycle_count !== 0 ||
            err_count !== 0 || done !== 0 || pass !== 0 || timeout !== 0 || fail_pc !== 0) begin
            bad++;
            $display("FAIL reset_midrun: busy=%b cpu_reset=%b instr=%h cyc=%0d err=%0d done=%b pass=%b to=%b fpc=%h",
                     busy, cpu_reset, instr, cycle_count, err_count, done, pass, timeout, fail_pc);
        end
        @(negedge clk); reset = 1'b0;
        for (int i = 0; i < IDEPTH; i++) m_val[i] = 1'b0;
        prog_len = 7'd3;
        pcq = '{0, 4, 8, 12};
        aluq = '{~m_exp[0], ~m_exp[1], ~m_exp[2], 0};
        run_prog("after_reset", 0, 3, 32'h0, 0);
    endtask

`ifdef TRACE_DMEM_EN
    task automatic test_dmem();
        prog_len = 7'd60;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); pc = 0; memwrite = 1; ALUresult = 32'd4; writedata = 32'hDEADBEEF;
        @(negedge clk); memwrite = 0;
        #1;
        total++;
        if (readdata !== 32'hDEADBEEF) begin
            bad++; $display("FAIL dmem_rw: got %h want deadbeef", readdata);
        end
        @(negedge clk); memwrite = 1; ALUresult = 32'd0; writedata = 32'h11;
        @(negedge clk); ALUresult = 32'(4 * DDEPTH); writedata = 32'h22;
        @(negedge clk); memwrite = 0;
        #1;
        total++;
        if (readdata !== 0) begin
            bad++; $display("FAIL dmem_oob_read: got %h want 0", readdata);
        end
        ALUresult = 32'd0;
        #1;
        total++;
        if (readdata !== 32'h11) begin
            bad++; $display("FAIL dmem_oob_write: got %h want 11", readdata);
        end
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        for (int i = 0; i < IDEPTH; i++) m_val[i] = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_match();
        test_mismatch();
        test_rerun();
        test_misaligned();
        test_boundary();
        test_random();
        test_load_busy();
        test_timeout();
        test_reset_midrun();
`ifdef TRACE_DMEM_EN
        test_dmem();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
